// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - 4-bit opcode encodings (OP_AND .. OP_NOR); 1101-1111 are illegal.
//   - FSM state type used by the top-level controller.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative unsigned multiplier / restoring divider.
//   Ports: clk, reset (async, active-high), start (latch operands),
//          op (MUL/MULHU/DIVU/REMU), a, b, done (one-cycle pulse on the
//          final iteration), result (value produced by that final iteration).
//   The divider datapath exists only when ALU_SEQ_DIV_EN is defined.
//   One 2*WIDTH-bit register is shared: for multiply it is the {hi,lo}
//   product accumulator (lo starts as the multiplier b); for divide it is
//   {remainder, quotient} (quotient half starts as the dividend a).
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [2*WIDTH-1:0] mul_nxt_s;
    logic [WIDTH-1:0]   opnd_r;
    logic [SHW-1:0]     cnt_r;
    logic               busy_r;
    logic               hi_r;
    logic               hi_sel_s;
    logic [WIDTH:0]     mul_sum_s;
`ifdef ALU_SEQ_DIV_EN
    logic               div_r;
    logic               div_sel_s;
    logic [2*WIDTH-1:0] div_nxt_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH:0]     div_diff_s;
`endif

    // Operation decode at start: which half of the accumulator is the answer
    always_comb begin
`ifdef ALU_SEQ_DIV_EN
        div_sel_s = (op == OP_DIVU) || (op == OP_REMU);
        hi_sel_s  = (op == OP_MULHU) || (op == OP_REMU);
`else
        hi_sel_s  = (op == OP_MULHU);
`endif
    end

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole accumulator right
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    // One restoring-divide step: shift the next dividend bit into the
    // remainder and keep the subtraction only if it did not go negative
    always_comb begin
        div_trial_s = acc_r[2*WIDTH-1:WIDTH-1];
        div_diff_s  = div_trial_s - {1'b0, opnd_r};
        if (div_diff_s[WIDTH] == 1'b0) begin
            div_nxt_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_nxt_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Select the active datapath step
    always_comb begin
        if (div_r) begin
            acc_nxt_s = div_nxt_s;
        end else begin
            acc_nxt_s = mul_nxt_s;
        end
    end
`else
    // Only the multiplier exists in this build
    always_comb begin
        acc_nxt_s = mul_nxt_s;
    end
`endif

    // Result is taken from the post-step value so it is ready on the final edge
    always_comb begin
        done = busy_r && (cnt_r == CNT_LAST);
        if (hi_r) begin
            result = acc_nxt_s[2*WIDTH-1:WIDTH];
        end else begin
            result = acc_nxt_s[WIDTH-1:0];
        end
    end

    // Operand latch, iteration counter and accumulator update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r  <= {(2*WIDTH){1'b0}};
            opnd_r <= {WIDTH{1'b0}};
            cnt_r  <= {SHW{1'b0}};
            busy_r <= 1'b0;
            hi_r   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_r  <= 1'b0;
`endif
        end else if (start) begin
            cnt_r  <= {SHW{1'b0}};
            busy_r <= 1'b1;
            hi_r   <= hi_sel_s;
`ifdef ALU_SEQ_DIV_EN
            div_r  <= div_sel_s;
            if (div_sel_s) begin
                acc_r  <= {{WIDTH{1'b0}}, a};
                opnd_r <= b;
            end else begin
                acc_r  <= {{WIDTH{1'b0}}, b};
                opnd_r <= a;
            end
`else
            acc_r  <= {{WIDTH{1'b0}}, b};
            opnd_r <= a;
`endif
        end else if (busy_r) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops plus iterative MUL/MULHU
// and (optionally) DIVU/REMU.
//   Ports: clk, reset (async, active-high),
//          in_valid/in_ready/aluop/a/b   - operand bundle input,
//          out_valid/out_ready           - result handshake,
//          result/zero/err               - registered result and flags.
//   Build option: define ALU_SEQ_DIV_EN to include the divider; otherwise
//   1010/1011 are treated as illegal opcodes (single cycle, err=1).
//   in_ready depends combinationally only on out_ready and internal state.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    state_t           state_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             err_r;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_err_s;
    logic             go_mul_s;
    logic             go_div_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             md_start_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_result_s;
    logic [SHW-1:0]   shamt_s;

    // Handshake: only idle and with room in the output register
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s;
        md_start_s = accept_s && (go_mul_s || go_div_s);
        shamt_s    = b[SHW-1:0];
    end

    // Single-cycle results and routing of multi-cycle opcodes
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_err_s = 1'b0;
        go_mul_s  = 1'b0;
        go_div_s  = 1'b0;
        case (aluop)
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_ADD: alu_res_s = a + b;
            OP_XOR: alu_res_s = a ^ b;
            OP_SLL: alu_res_s = a << shamt_s;
            OP_SRL: alu_res_s = a >> shamt_s;
            OP_SUB: alu_res_s = a - b;
            OP_SLT: begin
                if ($signed(a) < $signed(b)) begin
                    alu_res_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    alu_res_s = {WIDTH{1'b0}};
                end
            end
            OP_MUL, OP_MULHU: go_mul_s = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            // Divide by zero finishes immediately with the defined answers
            OP_DIVU: begin
                if (b == {WIDTH{1'b0}}) begin
                    alu_res_s = {WIDTH{1'b1}};
                end else begin
                    go_div_s = 1'b1;
                end
            end
            OP_REMU: begin
                if (b == {WIDTH{1'b0}}) begin
                    alu_res_s = a;
                end else begin
                    go_div_s = 1'b1;
                end
            end
`endif
            OP_NOR: alu_res_s = ~(a | b);
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_err_s = 1'b1;
            end
        endcase
    end

    alu_seq_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_s),
        .op     (aluop),
        .a      (a),
        .b      (b),
        .done   (md_done_s),
        .result (md_result_s)
    );

    // Controller FSM and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (go_mul_s) begin
                            state_r     <= ST_MUL;
                            out_valid_r <= 1'b0;
                        end else if (go_div_s) begin
                            state_r     <= ST_DIV;
                            out_valid_r <= 1'b0;
                        end else begin
                            // Replaces any result consumed this same cycle
                            out_valid_r <= 1'b1;
                            result_r    <= alu_res_s;
                            zero_r      <= (alu_res_s == {WIDTH{1'b0}});
                            err_r       <= alu_err_s;
                        end
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done_s) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b1;
                        result_r    <= md_result_s;
                        zero_r      <= (md_result_s == {WIDTH{1'b0}});
                        err_r       <= 1'b0;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign err       = err_r;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's single-cycle 32-bit ALU: keeps the 4-bit `aluop` encoding and `zero` flag, generalises the datapath width, and adds iterative multiply and unsigned divide/remainder. Sits between the decode stage and writeback of the Basys3 soft-core datapath. Operands enter through a valid/ready input port; results leave through a registered valid/ready output port.

## Interface
- `WIDTH`, 32: operand/result width in bits; even, ≥ 4.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, not overridden.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: operand bundle valid.
- `in_ready` out 1: block accepts the bundle this cycle.
- `aluop` in 4: operation select.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `out_valid` out 1: result register holds an unconsumed result.
- `out_ready` in 1: consumer takes the result this cycle.
- `result` out WIDTH: registered result.
- `zero` out 1: registered, 1 iff `result == 0`.
- `err` out 1: registered, 1 for an illegal or compiled-out opcode.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed, result 0/1), 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned), 1010 DIVU, 1011 REMU, 1100 NOR.
- 1101–1111 are illegal: result 0, zero 1, err 1.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Shifts use `b[SHW-1:0]` only; upper bits of `b` are ignored.
- FSM states:
  - IDLE: accepts new bundles.
  - MUL: shift-add, one bit per cycle, WIDTH iterations, 2·WIDTH-bit accumulator.
  - DIV: restoring divide, one quotient bit per cycle, WIDTH iterations.
- Transitions:
  - IDLE→MUL on accept of 1000/1001.
  - IDLE→DIV on accept of 1010/1011 with b≠0.
  - MUL/DIV→IDLE on the final iteration, loading the output register.
- Accept rule: `in_ready = (state==IDLE) && (!out_valid || out_ready)`. Accept happens when `in_valid && in_ready`; operands are latched at that edge.
- Divide by zero completes without iterating: DIVU gives all-ones, REMU gives `a`, err 0.
- Output register holds `result`/`zero`/`err` stable while `out_valid && !out_ready`.
- Simultaneous consume and new single-cycle result in the same cycle: the new result replaces the old one and `out_valid` stays 1.
- Reset at any time, including mid-iteration, aborts the operation. The partial result is discarded and never appears on the output.

## Timing
- Reset values: `out_valid` 0, `result` 0, `zero` 1, `err` 0, state IDLE. `in_ready` is 1 from the first edge after reset deasserts.
- Single-cycle ops and divide-by-zero: accepted at edge N → `out_valid` at N+1.
- MUL/MULHU/DIVU/REMU: accepted at edge N → `out_valid` at N+WIDTH+1; `in_ready` is 0 for edges N+1 … N+WIDTH.
- Peak throughput is one single-cycle op per clock when `out_ready` is held at 1.
- `in_ready` has no combinational path from `in_valid`; its only combinational input is `out_ready`.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIVU/REMU and the DIV state are built as specified.
- Not defined:
  - No divider hardware.
  - 1010/1011 behave as illegal opcodes: result 0, zero 1, err 1, latency 1.
  - MUL/MULHU are unaffected.

## Structure
- Package `alu_seq_pkg` holds:
  - opcode localparams (`OP_AND` … `OP_NOR`);
  - the FSM state typedef (`ST_IDLE`, `ST_MUL`, `ST_DIV`).
- One sub-module, `alu_seq_muldiv`, holds the iterative multiplier/divider:
  - inputs: start, op, a, b;
  - outputs: done pulse, result;
  - its internal counter runs 0…WIDTH-1.
- The top level holds the combinational single-cycle ops, the FSM, the handshake and the output register.

## Test plan
- Reset mid-MUL at iteration 10 → no `out_valid`; after reset `result` = 0, `zero` = 1, `in_ready` = 1.
- WIDTH=32, `out_ready` held 1:
  - ADD a=FFFFFFFF b=00000001 → result 00000000, zero 1, one cycle after accept;
  - SUB 5−7 → FFFFFFFE;
  - SLT a=FFFFFFFF b=00000001 → 00000001.
- MUL a=0001_0000 b=0001_0000 → result 00000000, zero 1. MULHU with the same operands → 00000001. Both at N+33; `in_ready` 0 for 32 cycles.
- DIVU 100/7 → 0000000E; REMU 100/7 → 00000002. DIVU x/0 → FFFFFFFF in 1 cycle. Without `ALU_SEQ_DIV_EN`, DIVU → result 0, err 1.
- Backpressure: `out_ready` 0 for 5 cycles after an AND result → `result` stable and `in_ready` 0 throughout. A new op is accepted in the cycle `out_ready` rises.
- Opcode 1111 → err 1, result 0, zero 1. A back-to-back stream of 20 random single-cycle ops matches a reference model with no bubbles.
